// File: rtl/nibble_pkg.sv
// nibble_pkg
// Shared widths, pairing-state encoding and word type for the nibble packer.
// Contents:
//   HALF_W, WORD_W, NIB_W - nibble group, packed word and nibble widths
//   pack_state_t          - pairing FSM states (ST_LOW, ST_HIGH)
//   word_t                - one packed 32-bit word
// Optional feature macro used by the importing files: NIBBLE_PACKER_PARITY_EN
package nibble_pkg;

   localparam int HALF_W = 16;
   localparam int WORD_W = 32;
   localparam int NIB_W  = 4;

   typedef enum logic [0:0] {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } pack_state_t;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/packer_fifo.sv
// packer_fifo
// Show-ahead synchronous FIFO for completed words. The head entry is driven
// combinationally from storage; pointers wrap modulo DEPTH (power of two).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   clr               - synchronous clear of pointers and count (beats push/pop)
//   push, din         - write request and data (accepted if not full or popping)
//   pop               - read request (ignored while empty)
//   dout              - head-of-FIFO entry
//   full, empty       - occupancy flags
//   count             - occupied entries
module packer_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [DATA_W-1:0]        din,
   input  logic                     pop,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A pop frees the slot in the same cycle, so a full FIFO can still accept.
   assign do_pop  = pop && !empty && !clr;
   assign do_push = push && !clr && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer
// Pairs consecutive 16-bit nibble groups into 32-bit words (first group low,
// second group high), buffers them in packer_fifo and offers them over a
// valid/ready handshake. Upstream has no backpressure: a word that cannot be
// stored is dropped and OVERFLOW is set (sticky until SYNC_CLR or reset).
// Ports:
//   CLK, RESET_L   - clock, asynchronous active-low reset
//   SYNC_CLR       - synchronous clear of pairing state, FIFO and OVERFLOW
//   NIBBLE_IN      - 16-bit nibble group, IN_VALID qualifies it
//   WORD_OUT       - head-of-FIFO word, OUT_VALID = FIFO not empty
//   OUT_READY      - consumer accepts WORD_OUT
//   FIFO_COUNT     - occupied FIFO entries
//   HALF_PENDING   - low half held, waiting for its partner
//   OVERFLOW       - sticky dropped-word flag
//   WORD_PAR       - per-byte even parity of WORD_OUT (only with
//                    NIBBLE_PACKER_PARITY_EN defined)
module nibble_packer
   import nibble_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET_L,
   input  logic                     SYNC_CLR,
   input  logic [HALF_W-1:0]        NIBBLE_IN,
   input  logic                     IN_VALID,
   output logic [WORD_W-1:0]        WORD_OUT,
`ifdef NIBBLE_PACKER_PARITY_EN
   output logic [3:0]               WORD_PAR,
`endif
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT,
   output logic                     HALF_PENDING,
   output logic                     OVERFLOW
);

`ifdef NIBBLE_PACKER_PARITY_EN
   localparam int ENTRY_W = WORD_W + 4;
`else
   localparam int ENTRY_W = WORD_W;
`endif

   pack_state_t         state;
   logic [HALF_W-1:0]   low_reg;
   logic                overflow_q;
   logic                hi_fire;
   logic                pop;
   logic                full;
   logic                empty;
   word_t               new_word;
   logic [ENTRY_W-1:0]  fifo_din;
   logic [ENTRY_W-1:0]  fifo_dout;

`ifdef NIBBLE_PACKER_PARITY_EN
   function automatic logic [3:0] byte_parity(input word_t w);
      logic [3:0] p;
      for (int b = 0; b < 4; b++) p[b] = ^w[8*b +: 8];
      return p;
   endfunction
`endif

   assign hi_fire  = IN_VALID && (state == ST_HIGH);
   assign new_word = {NIBBLE_IN, low_reg};
   assign pop      = !empty && OUT_READY;

`ifdef NIBBLE_PACKER_PARITY_EN
   // Parity is computed once at push time and stored with the word.
   assign fifo_din = {byte_parity(new_word), new_word};
   assign WORD_PAR = fifo_dout[WORD_W +: 4];
`else
   assign fifo_din = new_word;
`endif

   assign WORD_OUT     = fifo_dout[WORD_W-1:0];
   assign OUT_VALID    = !empty;
   assign HALF_PENDING = (state == ST_HIGH);
   assign OVERFLOW     = overflow_q;

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state      <= ST_LOW;
         low_reg    <= '0;
         overflow_q <= 1'b0;
      end else if (SYNC_CLR) begin
         state      <= ST_LOW;
         overflow_q <= 1'b0;
      end else if (IN_VALID) begin
         if (state == ST_LOW) begin
            low_reg <= NIBBLE_IN;
            state   <= ST_HIGH;
         end else begin
            // Return to ST_LOW even on a drop so pairing stays aligned.
            state <= ST_LOW;
            if (full && !pop) overflow_q <= 1'b1;
         end
      end
   end

   packer_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (ENTRY_W)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RESET_L),
      .clr   (SYNC_CLR),
      .push  (hi_fire),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (FIFO_COUNT)
   );

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer
// Self-checking bench for nibble_packer (DEPTH = 4). A queue-based reference
// model tracks the pairing state, stored words and overflow flag.
// Parity checks are compiled in when NIBBLE_PACKER_PARITY_EN is defined.
module tb_nibble_packer;
   import nibble_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic              CLK = 1'b0;
   logic              RESET_L = 1'b0;
   logic              SYNC_CLR = 1'b0;
   logic [15:0]       NIBBLE_IN = '0;
   logic              IN_VALID = 1'b0;
   logic [31:0]       WORD_OUT;
`ifdef NIBBLE_PACKER_PARITY_EN
   logic [3:0]        WORD_PAR;
`endif
   logic              OUT_VALID;
   logic              OUT_READY = 1'b0;
   logic [CW-1:0]     FIFO_COUNT;
   logic              HALF_PENDING;
   logic              OVERFLOW;

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [31:0] mq[$];
   bit          m_pend = 0;
   logic [15:0] m_low  = '0;
   bit          m_ovf  = 0;

   always #5 CLK = ~CLK;

   nibble_packer #(.DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .RESET_L      (RESET_L),
      .SYNC_CLR     (SYNC_CLR),
      .NIBBLE_IN    (NIBBLE_IN),
      .IN_VALID     (IN_VALID),
      .WORD_OUT     (WORD_OUT),
`ifdef NIBBLE_PACKER_PARITY_EN
      .WORD_PAR     (WORD_PAR),
`endif
      .OUT_VALID    (OUT_VALID),
      .OUT_READY    (OUT_READY),
      .FIFO_COUNT   (FIFO_COUNT),
      .HALF_PENDING (HALF_PENDING),
      .OVERFLOW     (OVERFLOW)
   );

   function automatic logic [3:0] exp_par(input logic [31:0] w);
      logic [3:0] p;
      for (int b = 0; b < 4; b++) begin
         int ones = 0;
         for (int k = 0; k < 8; k++) ones += int'(w[8*b+k]);
         p[b] = (ones % 2) == 1;
      end
      return p;
   endfunction

   // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
   task automatic step(input bit iv, input logic [15:0] nib, input bit rdy, input bit clr);
      bit          popped;
      bit          pushed;
      logic [31:0] w;
      IN_VALID  = iv;
      NIBBLE_IN = nib;
      OUT_READY = rdy;
      SYNC_CLR  = clr;
      pushed = 0;
      w = '0;
      if (clr) begin
         mq.delete();
         m_pend = 0;
         m_ovf  = 0;
      end else begin
         popped = (mq.size() > 0) && rdy;
         if (iv) begin
            if (!m_pend) begin
               m_low  = nib;
               m_pend = 1;
            end else begin
               m_pend = 0;
               w = {nib, m_low};
               if (mq.size() < DEPTH || popped) pushed = 1;
               else m_ovf = 1;
            end
         end
         if (popped) void'(mq.pop_front());
         if (pushed) mq.push_back(w);
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      SYNC_CLR = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      m_pend = 0;
      m_ovf  = 0;
      m_low  = '0;
   endtask

   task automatic test_reset();
      RESET_L = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      total++; if (WORD_OUT !== 32'h0) begin bad++; $display("FAIL reset_word got %h want 0", WORD_OUT); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", OUT_VALID); end
      total++; if (FIFO_COUNT !== '0) begin bad++; $display("FAIL reset_count got %0d want 0", FIFO_COUNT); end
      total++; if (HALF_PENDING !== 1'b0) begin bad++; $display("FAIL reset_half got %b want 0", HALF_PENDING); end
      total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", OVERFLOW); end
`ifdef NIBBLE_PACKER_PARITY_EN
      total++; if (WORD_PAR !== 4'h0) begin bad++; $display("FAIL reset_par got %h want 0", WORD_PAR); end
`endif
      RESET_L = 1'b1;
      model_reset();
   endtask

   task automatic test_basic_pair();
      step(1, 16'h3210, 1, 0);
      total++; if (HALF_PENDING !== 1'b1) begin bad++; $display("FAIL pair_half got %b want 1", HALF_PENDING); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL pair_early_valid got %b want 0", OUT_VALID); end
      step(1, 16'h7654, 1, 0);
      total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL pair_valid got %b want 1", OUT_VALID); end
      total++; if (WORD_OUT !== 32'h76543210) begin bad++; $display("FAIL pair_word got %h want 76543210", WORD_OUT); end
      total++; if (HALF_PENDING !== 1'b0) begin bad++; $display("FAIL pair_half_done got %b want 0", HALF_PENDING); end
      step(0, 16'h0, 1, 0);
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL pair_drained got %b want 0", OUT_VALID); end
   endtask

   task automatic test_gap();
      step(1, 16'hAAAA, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 16'($urandom), 0, 0);
         total++; if (HALF_PENDING !== 1'b1) begin bad++; $display("FAIL gap_half[%0d] got %b want 1", i, HALF_PENDING); end
      end
      step(1, 16'h5555, 0, 0);
      total++; if (WORD_OUT !== 32'h5555AAAA) begin bad++; $display("FAIL gap_word got %h want 5555aaaa", WORD_OUT); end
      total++; if (FIFO_COUNT !== CW'(1)) begin bad++; $display("FAIL gap_count got %0d want 1", FIFO_COUNT); end
      step(0, 16'h0, 1, 0);
   endtask

   task automatic test_fill_overflow();
      logic [15:0] g [10];
      logic [31:0] exp_w [4];
      for (int i = 0; i < 10; i++) g[i] = 16'($urandom);
      for (int i = 0; i < 4; i++) exp_w[i] = {g[2*i+1], g[2*i]};
      for (int i = 0; i < 9; i++) step(1, g[i], 0, 0);
      total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got %b want 0", OVERFLOW); end
      step(1, g[9], 0, 0);
      total++; if (FIFO_COUNT !== CW'(4)) begin bad++; $display("FAIL fill_count got %0d want 4", FIFO_COUNT); end
      total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL fill_ovf got %b want 1", OVERFLOW); end
      total++; if (HALF_PENDING !== 1'b0) begin bad++; $display("FAIL fill_half got %b want 0", HALF_PENDING); end
      for (int i = 0; i < 4; i++) begin
         total++; if (WORD_OUT !== exp_w[i]) begin bad++; $display("FAIL drain_word[%0d] got %h want %h", i, WORD_OUT, exp_w[i]); end
         step(0, 16'h0, 1, 0);
      end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL drain_empty got %b want 0", OUT_VALID); end
      total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL drain_ovf_sticky got %b want 1", OVERFLOW); end
      step(0, 16'h0, 0, 1);
      total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL clr_ovf got %b want 0", OVERFLOW); end
   endtask

   task automatic test_push_pop_full();
      logic [15:0] lo;
      logic [15:0] hi;
      logic [31:0] exp_w [4];
      for (int i = 0; i < 4; i++) begin
         lo = 16'($urandom); hi = 16'($urandom);
         exp_w[i] = {hi, lo};
         step(1, lo, 0, 0);
         step(1, hi, 0, 0);
      end
      lo = 16'($urandom); hi = 16'($urandom);
      step(1, lo, 0, 0);
      step(1, hi, 1, 0);
      total++; if (FIFO_COUNT !== CW'(4)) begin bad++; $display("FAIL ppf_count got %0d want 4", FIFO_COUNT); end
      total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ppf_ovf got %b want 0", OVERFLOW); end
      for (int i = 1; i < 4; i++) begin
         total++; if (WORD_OUT !== exp_w[i]) begin bad++; $display("FAIL ppf_word[%0d] got %h want %h", i, WORD_OUT, exp_w[i]); end
         step(0, 16'h0, 1, 0);
      end
      total++; if (WORD_OUT !== {hi, lo}) begin bad++; $display("FAIL ppf_last got %h want %h", WORD_OUT, {hi, lo}); end
      step(0, 16'h0, 1, 0);
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL ppf_empty got %b want 0", OUT_VALID); end
   endtask

   task automatic test_sync_clr();
      for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0, 0);
      total++; if (FIFO_COUNT !== CW'(2) || HALF_PENDING !== 1'b1) begin bad++; $display("FAIL clr_setup got count=%0d half=%b want 2/1", FIFO_COUNT, HALF_PENDING); end
      step(1, 16'hFFFF, 1, 1);
      total++; if (FIFO_COUNT !== '0) begin bad++; $display("FAIL clr_count got %0d want 0", FIFO_COUNT); end
      total++; if (HALF_PENDING !== 1'b0) begin bad++; $display("FAIL clr_half got %b want 0", HALF_PENDING); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL clr_valid got %b want 0", OUT_VALID); end
      step(1, 16'h1234, 0, 0);
      total++; if (HALF_PENDING !== 1'b1) begin bad++; $display("FAIL clr_relow got %b want 1", HALF_PENDING); end
      step(1, 16'h9ABC, 0, 0);
      total++; if (WORD_OUT !== 32'h9ABC1234) begin bad++; $display("FAIL clr_word got %h want 9abc1234", WORD_OUT); end
   endtask

   task automatic test_async_reset();
      step(1, 16'($urandom), 0, 0);
      step(1, 16'($urandom), 0, 0);
      step(1, 16'($urandom), 0, 0);
      #2;
      RESET_L = 1'b0;
      #1;
      total++; if (WORD_OUT !== 32'h0) begin bad++; $display("FAIL arst_word got %h want 0", WORD_OUT); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", OUT_VALID); end
      total++; if (FIFO_COUNT !== '0) begin bad++; $display("FAIL arst_count got %0d want 0", FIFO_COUNT); end
      total++; if (HALF_PENDING !== 1'b0) begin bad++; $display("FAIL arst_half got %b want 0", HALF_PENDING); end
      total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL arst_ovf got %b want 0", OVERFLOW); end
      #1;
      RESET_L = 1'b1;
      model_reset();
   endtask

   task automatic test_parity();
`ifdef NIBBLE_PACKER_PARITY_EN
      step(1, 16'h0007, 0, 0);
      step(1, 16'h0103, 0, 0);
      total++; if (WORD_PAR !== exp_par(32'h01030007)) begin bad++; $display("FAIL par_word got %b want %b", WORD_PAR, exp_par(32'h01030007)); end
      step(0, 16'h0, 1, 0);
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step(bit'($urandom_range(0, 3) != 0), 16'($urandom), bit'($urandom_range(0, 9) < 4),
              bit'($urandom_range(0, 59) == 0));
         total++; if (OUT_VALID !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got %b want %b", n, OUT_VALID, mq.size() != 0); end
         total++; if (FIFO_COUNT !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, FIFO_COUNT, mq.size()); end
         total++; if (HALF_PENDING !== m_pend) begin bad++; $display("FAIL rnd_half[%0d] got %b want %b", n, HALF_PENDING, m_pend); end
         total++; if (OVERFLOW !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got %b want %b", n, OVERFLOW, m_ovf); end
         if (mq.size() != 0) begin
            total++; if (WORD_OUT !== mq[0]) begin bad++; $display("FAIL rnd_word[%0d] got %h want %h", n, WORD_OUT, mq[0]); end
`ifdef NIBBLE_PACKER_PARITY_EN
            total++; if (WORD_PAR !== exp_par(mq[0])) begin bad++; $display("FAIL rnd_par[%0d] got %b want %b", n, WORD_PAR, exp_par(mq[0])); end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_pair();
      test_gap();
      test_fill_overflow();
      test_push_pop_full();
      test_sync_clr();
      test_async_reset();
      test_parity();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
